// File: rtl/polyvec_eta_sequencer.sv
// polyvec_eta_sequencer: runs one eta sampler L+K times (nonce NONCE_BASE+i) from a
// latched seed. Each polynomial is captured and offered on a valid/ack port.
// Ports: clock/reset (sync, active-high), rtr/linear_seed start a run, eng_* drive and
// observe the sampler, poly_* carry the captured polynomial, busy/rts report progress.
module polyvec_eta_sequencer #(
  parameter int          L          = 4,
  parameter int          K          = 4,
  parameter logic [15:0] NONCE_BASE = 16'h0000,
  parameter int          GAP_CYCLES = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rtr,
  input  logic [511:0]  linear_seed,
  output logic          eng_rtr,
  output logic [511:0]  eng_seed,
  output logic [15:0]   eng_nonce,
  input  logic          eng_rts,
  input  logic [8191:0] eng_a,
  output logic [8191:0] poly_out,
  output logic [7:0]    poly_idx,
  output logic          poly_is_s2,
  output logic          poly_valid,
  input  logic          poly_ack,
  output logic          busy,
  output logic          rts
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_PUSH,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [7:0]  LAST    = 8'(L + K - 1);
  localparam logic [7:0]  L_IDX   = 8'(L);
  localparam logic [15:0] GAP_END = 16'(GAP_CYCLES);

  state_t        state_q, state_d;
  logic          eng_rtr_q, eng_rtr_d;
  logic [511:0]  seed_q, seed_d;
  logic [15:0]   nonce_q, nonce_d;
  logic [8191:0] poly_q, poly_d;
  logic [7:0]    pidx_q, pidx_d;
  logic          s2_q, s2_d;
  logic          valid_q, valid_d;
  logic [7:0]    idx_q, idx_d;
  logic [15:0]   gap_q, gap_d;
  logic          gap_done;

  // Only idle cycles (engine not signalling done) count toward the gap.
  assign gap_done = (GAP_END == 16'd0) ||
                    (!eng_rts && (gap_q + 16'd1 == GAP_END));

  always_comb begin
    state_d   = state_q;
    eng_rtr_d = eng_rtr_q;
    seed_d    = seed_q;
    nonce_d   = nonce_q;
    poly_d    = poly_q;
    pidx_d    = pidx_q;
    s2_d      = s2_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (rtr) begin
          seed_d    = linear_seed;
          idx_d     = 8'd0;
          nonce_d   = NONCE_BASE;
          eng_rtr_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (eng_rts) begin
          poly_d    = eng_a;
          pidx_d    = idx_q;
          s2_d      = (idx_q >= L_IDX);
          valid_d   = 1'b1;
          eng_rtr_d = 1'b0;
          state_d   = S_PUSH;
        end
      end
      S_PUSH: begin
        if (poly_ack) begin
          valid_d = 1'b0;
          gap_d   = 16'd0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (!eng_rts) gap_d = gap_q + 16'd1;
        if (gap_done) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d     = idx_q + 8'd1;
            nonce_d   = NONCE_BASE + {8'd0, idx_q} + 16'd1;
            eng_rtr_d = 1'b1;
            state_d   = S_REQ;
          end
        end
      end
      S_DONE: begin
        if (!rtr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      eng_rtr_q <= 1'b0;
      seed_q    <= '0;
      nonce_q   <= '0;
      poly_q    <= '0;
      pidx_q    <= '0;
      s2_q      <= 1'b0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      eng_rtr_q <= eng_rtr_d;
      seed_q    <= seed_d;
      nonce_q   <= nonce_d;
      poly_q    <= poly_d;
      pidx_q    <= pidx_d;
      s2_q      <= s2_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
    end
  end

  assign eng_rtr    = eng_rtr_q;
  assign eng_seed   = seed_q;
  assign eng_nonce  = nonce_q;
  assign poly_out   = poly_q;
  assign poly_idx   = pidx_q;
  assign poly_is_s2 = s2_q;
  assign poly_valid = valid_q;
  assign busy       = (state_q == S_REQ) || (state_q == S_PUSH) ||
                      (state_q == S_GAP);
  assign rts        = (state_q == S_DONE);

endmodule

// File: tb/tb_polyvec_eta_sequencer.sv
// tb_polyvec_eta_sequencer: table-driven and randomized runs of the sequencer
// against an engine model and a list-of-transfers reference.
module tb_polyvec_eta_sequencer;

  logic          clk = 1'b0;
  logic          reset;
  logic          rtr;
  logic [511:0]  seed;
  logic          eng_rtr;
  logic [511:0]  eng_seed;
  logic [15:0]   eng_nonce;
  logic          eng_rts;
  logic [8191:0] eng_a;
  logic [8191:0] poly_out;
  logic [7:0]    poly_idx;
  logic          poly_is_s2;
  logic          poly_valid;
  logic          poly_ack;
  logic          busy;
  logic          rts;

  logic          rtr_b;
  logic [511:0]  seed_b;
  logic          eng_rtr_b;
  logic [511:0]  eng_seed_b;
  logic [15:0]   eng_nonce_b;
  logic          eng_rts_b;
  logic [8191:0] eng_a_b;
  logic [8191:0] poly_out_b;
  logic [7:0]    poly_idx_b;
  logic          poly_is_s2_b;
  logic          poly_valid_b;
  logic          poly_ack_b;
  logic          busy_b;
  logic          rts_b;

  always #5 clk = ~clk;

  polyvec_eta_sequencer dut (
    .clock(clk), .reset(reset), .rtr(rtr), .linear_seed(seed),
    .eng_rtr(eng_rtr), .eng_seed(eng_seed), .eng_nonce(eng_nonce),
    .eng_rts(eng_rts), .eng_a(eng_a), .poly_out(poly_out),
    .poly_idx(poly_idx), .poly_is_s2(poly_is_s2), .poly_valid(poly_valid),
    .poly_ack(poly_ack), .busy(busy), .rts(rts)
  );

  polyvec_eta_sequencer #(.L(2), .K(2), .NONCE_BASE(16'hFFFE)) dut_b (
    .clock(clk), .reset(reset), .rtr(rtr_b), .linear_seed(seed_b),
    .eng_rtr(eng_rtr_b), .eng_seed(eng_seed_b), .eng_nonce(eng_nonce_b),
    .eng_rts(eng_rts_b), .eng_a(eng_a_b), .poly_out(poly_out_b),
    .poly_idx(poly_idx_b), .poly_is_s2(poly_is_s2_b),
    .poly_valid(poly_valid_b), .poly_ack(poly_ack_b), .busy(busy_b),
    .rts(rts_b)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic chk_poly(input string nm, input logic [8191:0] act,
                          input logic [8191:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got low %h want low %h", nm, act[63:0], exp[63:0]);
  endtask

  // Reference sampler output: a fixed function of seed and nonce.
  function automatic logic [8191:0] poly_of(input logic [511:0] s,
                                            input logic [15:0] n);
    logic [8191:0] p;
    for (int j = 0; j < 256; j++)
      p[j*32 +: 32] = s[31:0] ^ s[511:480] ^ {8'(j), 8'h5a, n};
    return p;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  typedef struct {
    int lat;
    int hold;
    int blk;
    int cyc;
    bit drop;
    bit chg;
    bit rnd;
    int nx;
  } vec_t;

  function automatic vec_t mk(input int lat, hold, blk, cyc,
                              input bit drop, chg, rnd, input int nx);
    vec_t v;
    v.lat = lat; v.hold = hold; v.blk = blk; v.cyc = cyc;
    v.drop = drop; v.chg = chg; v.rnd = rnd; v.nx = nx;
    return v;
  endfunction

  // Run control shared with the models (written only by the main process).
  int           run_id = 0;
  logic [511:0] run_seed = '0;
  int           eng_lat = 1;
  int           eng_hold = 0;
  int           ack_blk = -1;
  int           ack_cyc = 0;
  bit           ack_rnd = 0;

  // Engine model for dut.
  int ecnt = 0;
  int ehold = 0;
  always begin
    @(posedge clk); #2;
    if (reset) begin
      eng_rts = 1'b0; ecnt = 0; ehold = 0;
    end else if (eng_rtr) begin
      if (!eng_rts) begin
        ecnt++;
        if (ecnt >= eng_lat) begin
          eng_rts = 1'b1;
          eng_a = poly_of(eng_seed, eng_nonce);
          ehold = eng_hold;
        end
      end
    end else begin
      ecnt = 0;
      if (eng_rts) begin
        if (ehold > 0) ehold--;
        else eng_rts = 1'b0;
      end
    end
  end

  // Consumer model for dut.
  int ack_wait = 0;
  int ack_seen = -1;
  always begin
    @(posedge clk); #2;
    if (ack_seen != run_id) begin ack_seen = run_id; ack_wait = 0; end
    if (poly_valid && ack_blk >= 0 && poly_idx == 8'(ack_blk) &&
        ack_wait < ack_cyc) begin
      poly_ack = 1'b0;
      ack_wait++;
    end else begin
      poly_ack = ack_rnd ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Scoreboard for dut: expected transfer i carries nonce i, is_s2 = i>=4.
  int            req_cnt = 0;
  int            xfers = 0;
  int            gap_zero = 0;
  int            mon_id = -1;
  bit            prev_rtr = 0;
  bit            hold_v = 0;
  logic [7:0]    sv_idx;
  logic [8191:0] sv_poly;
  always @(negedge clk) begin
    if (mon_id != run_id) begin
      mon_id = run_id; req_cnt = 0; xfers = 0; gap_zero = 0;
    end
    if (reset) begin
      prev_rtr = 0; hold_v = 0;
    end else begin
      if (eng_rtr && !prev_rtr) begin
        chk("req_nonce", 64'(eng_nonce), 64'(req_cnt));
        chk("req_seed", 64'(eng_seed == run_seed), 64'd1);
        chk("req_order", 64'(req_cnt), 64'(xfers));
        if (req_cnt > 0) chk("gap_idle", 64'(gap_zero), 64'd2);
        req_cnt++;
      end
      if (poly_valid) begin
        chk("push_no_req", 64'(eng_rtr), 64'd0);
        if (hold_v) begin
          chk("hold_idx", 64'(poly_idx), 64'(sv_idx));
          chk_poly("hold_poly", poly_out, sv_poly);
        end
        if (poly_ack) begin
          chk("xfer_idx", 64'(poly_idx), 64'(xfers));
          chk("xfer_s2", 64'(poly_is_s2), 64'(xfers >= 4));
          chk_poly("xfer_poly", poly_out, poly_of(run_seed, 16'(xfers)));
          xfers++;
          gap_zero = 0;
          hold_v = 0;
        end else begin
          hold_v = 1; sv_idx = poly_idx; sv_poly = poly_out;
        end
      end else begin
        hold_v = 0;
        if (!eng_rtr && !eng_rts) gap_zero++;
      end
      prev_rtr = eng_rtr;
    end
  end

  // Engine and scoreboard for dut_b.
  int cnt_b = 0;
  always begin
    @(posedge clk); #2;
    poly_ack_b = 1'b1;
    if (reset || !eng_rtr_b) begin
      eng_rts_b = 1'b0; cnt_b = 0;
    end else if (!eng_rts_b) begin
      cnt_b++;
      if (cnt_b >= 3) begin
        eng_rts_b = 1'b1;
        eng_a_b = poly_of(eng_seed_b, eng_nonce_b);
      end
    end
  end

  logic [15:0] nq[$];
  int          xb = 0;
  bit          prev_rtr_b = 0;
  logic [15:0] nb;
  always @(negedge clk) begin
    if (!reset) begin
      if (eng_rtr_b && !prev_rtr_b) nq.push_back(eng_nonce_b);
      prev_rtr_b = eng_rtr_b;
      if (poly_valid_b && poly_ack_b) begin
        nb = 16'hFFFE + 16'(xb);
        chk("b_idx", 64'(poly_idx_b), 64'(xb));
        chk("b_s2", 64'(poly_is_s2_b), 64'(xb >= 2));
        chk_poly("b_poly", poly_out_b, poly_of(seed_b, nb));
        xb++;
      end
    end else begin
      prev_rtr_b = 0;
    end
  end

  task automatic run_once(input vec_t v);
    logic [511:0] s;
    int c;
    s = rnd512();
    eng_lat = v.lat; eng_hold = v.hold; ack_blk = v.blk; ack_cyc = v.cyc;
    ack_rnd = v.rnd; run_seed = s; run_id++;
    seed = s; rtr = 1'b1;
    @(negedge clk);
    chk("start_lat", 64'(eng_rtr), 64'd1);
    chk("busy_run", 64'(busy), 64'd1);
    if (v.drop) rtr = 1'b0;
    c = 0;
    while (!rts && c < 4000) begin
      @(negedge clk);
      c++;
      if (v.chg) seed = rnd512();
    end
    chk("done_seen", 64'(rts), 64'd1);
    chk("xfer_cnt", 64'(xfers), 64'(v.nx));
    chk("busy_done", 64'(busy), 64'd0);
    chk("seed_kept", 64'(eng_seed == s), 64'd1);
    rtr = 1'b0;
    @(negedge clk);
    chk("rts_drop", 64'(rts), 64'd0);
  endtask

  vec_t tbl[5];

  initial begin
    int c;
    logic [15:0] en;
    tbl[0] = mk(20, 0, -1, 0, 0, 0, 0, 8);
    tbl[1] = mk(5,  0,  2, 6, 0, 0, 0, 8);
    tbl[2] = mk(4,  5, -1, 0, 0, 0, 0, 8);
    tbl[3] = mk(3,  0, -1, 0, 1, 1, 0, 8);
    tbl[4] = mk(1,  2,  5, 3, 1, 0, 1, 8);

    reset = 1'b1; rtr = 1'b0; seed = '0; rtr_b = 1'b0; seed_b = '0;
    eng_rts = 1'b0; eng_a = '0; poly_ack = 1'b1;
    eng_rts_b = 1'b0; eng_a_b = '0; poly_ack_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_eng_rtr", 64'(eng_rtr), 64'd0);
    chk("rst_valid", 64'(poly_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rts", 64'(rts), 64'd0);
    chk("rst_nonce", 64'(eng_nonce), 64'd0);
    chk("rst_idx", 64'(poly_idx), 64'd0);
    chk("rst_seed", 64'(|eng_seed), 64'd0);
    chk("rst_poly", 64'(|poly_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_once(tbl[i]);

    for (int r = 0; r < 4; r++)
      run_once(mk($urandom_range(1, 8), $urandom_range(0, 3),
                  $urandom_range(0, 7), $urandom_range(0, 4),
                  1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 8));

    // Abort in the middle of the request for idx 3.
    eng_lat = 6; eng_hold = 0; ack_blk = -1; ack_rnd = 0;
    run_seed = rnd512(); run_id++;
    seed = run_seed; rtr = 1'b1;
    c = 0;
    while (!(eng_rtr && eng_nonce == 16'd3) && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("abort_reach", 64'(eng_nonce), 64'd3);
    rtr = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("abort_eng_rtr", 64'(eng_rtr), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(poly_valid), 64'd0);
    chk("abort_nonce", 64'(eng_nonce), 64'd0);
    chk("abort_idx", 64'(poly_idx), 64'd0);
    chk("abort_seed", 64'(|eng_seed), 64'd0);
    chk("abort_rts", 64'(rts), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    run_once(tbl[0]);

    // Nonce wrap and rtr held high in DONE on the small instance.
    seed_b = rnd512(); rtr_b = 1'b1;
    c = 0;
    while (!rts_b && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("b_done", 64'(rts_b), 64'd1);
    chk("b_xfers", 64'(xb), 64'd4);
    chk("b_nreq", 64'(nq.size()), 64'd4);
    for (int i = 0; i < 4 && i < nq.size(); i++) begin
      en = 16'hFFFE + 16'(i);
      chk("b_nonce", 64'(nq[i]), 64'(en));
    end
    repeat (6) begin
      @(negedge clk);
      chk("b_hold_rts", 64'(rts_b), 64'd1);
      chk("b_hold_norq", 64'(eng_rtr_b), 64'd0);
    end
    rtr_b = 1'b0;
    @(negedge clk);
    chk("b_idle_rts", 64'(rts_b), 64'd0);
    chk("b_idle_norq", 64'(eng_rtr_b), 64'd0);
    rtr_b = 1'b1;
    @(negedge clk);
    chk("b_restart", 64'(eng_rtr_b), 64'd1);
    chk("b_restart_n", 64'(eng_nonce_b), 64'hFFFE);
    rtr_b = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
